ahfp_lzc_norm_pipe: RTL and testbench

//  Parametrised, pipelined leading-zero/leading-one counter and normaliser for the ahfp add/sub datapath.
//  - Counts leading zeros, or leading ones in mode=1 for two's-complement magnitudes.
//  - Left-shifts the mantissa by that count and carries a sideband tag (exponent/sign) alongside.
//  - Generalises the fixed 48-bit combinational LZD: pipelined, with a valid/ready handshake.

---
 rtl/ahfp_lzc_norm_pipe_if.sv | 33 +++
 rtl/ahfp_lzc_norm_pipe.sv | 152 +++++++++++++++
 tb/tb_ahfp_lzc_norm_pipe.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/ahfp_lzc_norm_pipe_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ahfp_lzc_norm_pipe_if: handshake/data bundle for the LZC pipe    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface ahfp_lzc_norm_pipe_if #(
  parameter int WIDTH = 48,
  parameter int CNT_W = 7,
  parameter int TAG_W = 9
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_mode;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] out_count;
  logic [WIDTH-1:0] out_norm;
  logic             out_all_same;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_data, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_count, out_norm, out_all_same, out_tag
  );

  modport slave (
    input  in_valid, in_data, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_count, out_norm, out_all_same, out_tag
  );
endinterface
`default_nettype wire

// File: rtl/ahfp_lzc_norm_pipe.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ahfp_lzc_norm_pipe: pipelined leading-zero/one count + normalise |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module ahfp_lzc_norm_pipe #(
  parameter int WIDTH  = 48,
  parameter int CNT_W  = 7,
  parameter int STAGES = 2,
  parameter int TAG_W  = 9
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  ahfp_lzc_norm_pipe_if.slave bus
);

  localparam int NG   = (WIDTH + 15) / 16;
  localparam int PW   = NG * 16;
  localparam int NMID = (STAGES > 1) ? STAGES - 1 : 1;

  typedef struct packed {
    logic [NG-1:0]      zero;
    logic [NG-1:0][3:0] lcnt;
    logic [WIDTH-1:0]   data;
    logic [TAG_W-1:0]   tag;
  } grp_t;

  logic             adv;
  logic             in_fire;
  logic [PW-1:0]    scan;
  grp_t             grp_in;
  grp_t             merge_src;
  logic             merge_valid;
  logic [CNT_W-1:0] m_count;
  logic             m_all_same;
  logic [WIDTH-1:0] m_norm;

  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic [WIDTH-1:0] out_norm_q, out_norm_d;
  logic             out_all_same_q, out_all_same_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;

  assign adv          = ~out_valid_q | bus.out_ready;
  assign bus.in_ready = adv & rst_n;
  assign in_fire      = bus.in_valid & bus.in_ready;

  // Leading ones become leading zeros after inversion; left-aligning into
  // PW bits zero-pads the low end, so the pad never precedes a real bit.
  always_comb begin : p_group
    scan = '0;
    scan[PW-1 -: WIDTH] = bus.in_mode ? ~bus.in_data : bus.in_data;
    grp_in.data = bus.in_data;
    grp_in.tag  = bus.in_tag;
    for (int g = 0; g < NG; g++) begin
      grp_in.zero[g] = ~|scan[g*16 +: 16];
      grp_in.lcnt[g] = 4'd0;
      for (int b = 0; b < 16; b++) begin
        if (scan[g*16 + b]) grp_in.lcnt[g] = 4'(15 - b);
      end
    end
  end

  generate
    if (STAGES > 1) begin : g_mid
      grp_t             mid_q [NMID];
      grp_t             mid_d [NMID];
      logic [NMID-1:0]  mid_valid_q, mid_valid_d;

      always_comb begin : p_mid_next
        mid_valid_d = mid_valid_q;
        mid_d       = mid_q;
        if (adv) begin
          mid_valid_d[0] = in_fire;
          if (in_fire) mid_d[0] = grp_in;
          for (int k = 1; k < NMID; k++) begin
            mid_valid_d[k] = mid_valid_q[k-1];
            if (mid_valid_q[k-1]) mid_d[k] = mid_q[k-1];
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin : p_mid_reg
        if (!rst_n) begin
          mid_valid_q <= '0;
          for (int k = 0; k < NMID; k++) mid_q[k] <= '0;
        end else begin
          mid_valid_q <= mid_valid_d;
          mid_q       <= mid_d;
        end
      end

      assign merge_src   = mid_q[NMID-1];
      assign merge_valid = mid_valid_q[NMID-1];
    end else begin : g_direct
      assign merge_src   = grp_in;
      assign merge_valid = in_fire;
    end
  endgenerate

  // Highest non-zero group wins; ascending scan lets the last hit override.
  always_comb begin : p_merge
    m_count = CNT_W'(WIDTH);
    for (int g = 0; g < NG; g++) begin
      if (!merge_src.zero[g])
        m_count = CNT_W'((NG - 1 - g) * 16) + CNT_W'(merge_src.lcnt[g]);
    end
    m_all_same = &merge_src.zero;
    m_norm     = merge_src.data << m_count;
  end

  always_comb begin : p_out_next
    out_valid_d    = out_valid_q;
    out_count_d    = out_count_q;
    out_norm_d     = out_norm_q;
    out_all_same_d = out_all_same_q;
    out_tag_d      = out_tag_q;
    if (adv) begin
      out_valid_d = merge_valid;
      if (merge_valid) begin
        out_count_d    = m_count;
        out_norm_d     = m_norm;
        out_all_same_d = m_all_same;
        out_tag_d      = merge_src.tag;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : p_out_reg
    if (!rst_n) begin
      out_valid_q    <= 1'b0;
      out_count_q    <= '0;
      out_norm_q     <= '0;
      out_all_same_q <= 1'b0;
      out_tag_q      <= '0;
    end else begin
      out_valid_q    <= out_valid_d;
      out_count_q    <= out_count_d;
      out_norm_q     <= out_norm_d;
      out_all_same_q <= out_all_same_d;
      out_tag_q      <= out_tag_d;
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.out_count    = out_count_q;
  assign bus.out_norm     = out_norm_q;
  assign bus.out_all_same = out_all_same_q;
  assign bus.out_tag      = out_tag_q;

endmodule
`default_nettype wire

// File: tb/tb_ahfp_lzc_norm_pipe.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_ahfp_lzc_norm_pipe: directed bench for the LZC/normalise pipe |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_ahfp_lzc_norm_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ahfp_lzc_norm_pipe_if #(.WIDTH(48), .CNT_W(7), .TAG_W(9)) bus ();

  ahfp_lzc_norm_pipe #(.WIDTH(48), .CNT_W(7), .STAGES(2), .TAG_W(9)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Directed vectors: data, mode, and hand-computed count / norm / all_same.
  logic [47:0] v_data [14] = '{
    48'h8000_0000_0000, 48'h0000_0000_0001, 48'h0000_0000_0000, 48'hFFF0_1234_5678,
    48'hFFFF_FFFF_FFFF, 48'h0000_8000_0000, 48'h0001_0000_0000, 48'h0000_0000_F000,
    48'h7FFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFE, 48'h0000_0000_0000, 48'hFFFF_FFFF_FFFF,
    48'h0000_0000_0003, 48'hFFFF_0000_0000};
  logic        v_mode [14] = '{0, 0, 0, 1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 1};
  logic [6:0]  v_cnt  [14] = '{0, 47, 48, 12, 48, 16, 15, 32, 0, 47, 0, 0, 46, 16};
  logic [47:0] v_norm [14] = '{
    48'h8000_0000_0000, 48'h8000_0000_0000, 48'h0000_0000_0000, 48'h0123_4567_8000,
    48'h0000_0000_0000, 48'h8000_0000_0000, 48'h8000_0000_0000, 48'hF000_0000_0000,
    48'h7FFF_FFFF_FFFF, 48'h0000_0000_0000, 48'h0000_0000_0000, 48'hFFFF_FFFF_FFFF,
    48'hC000_0000_0000, 48'h0000_0000_0000};
  logic        v_same [14] = '{0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};

  int cur_idx = 0;
  int sb[$];
  int run_len = 0;
  int max_run = 0;

  function automatic logic [8:0] tag_of(input int idx);
    return (idx == 0) ? 9'h07F : 9'(idx * 37 + 16);
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic send(input int idx);
    int  waited = 0;
    bit  fired  = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = v_data[idx];
    bus.in_mode  = v_mode[idx];
    bus.in_tag   = tag_of(idx);
    cur_idx      = idx;
    while (!fired && waited < 100) begin
      @(negedge clk);
      fired = bus.in_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    bus.in_valid = 1'b0;
    if (!fired) check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic single(input int idx);
    send(idx);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Scoreboard of accepted beats, checked as each result transfers.
  always @(negedge clk) begin
    int idx;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_beat", 64'd1, 64'd0);
      end else begin
        idx = sb.pop_front();
        check($sformatf("count[%0d]", idx), 64'(bus.out_count), 64'(v_cnt[idx]));
        check($sformatf("norm[%0d]", idx), 64'(bus.out_norm), 64'(v_norm[idx]));
        check($sformatf("all_same[%0d]", idx), 64'(bus.out_all_same), 64'(v_same[idx]));
        check($sformatf("tag[%0d]", idx), 64'(bus.out_tag), 64'(tag_of(idx)));
      end
    end
    if (rst_n && bus.in_valid && bus.in_ready) sb.push_back(cur_idx);
    if (bus.out_valid && bus.out_ready) run_len++;
    else run_len = 0;
    if (run_len > max_run) max_run = run_len;
  end

  initial begin
    logic [6:0]  snap_cnt;
    logic [47:0] snap_norm;
    logic [8:0]  snap_tag;
    int          w;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_mode   = 1'b0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;

    // Reset state
    #3;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_count", 64'(bus.out_count), 64'd0);
    check("rst_norm", 64'(bus.out_norm), 64'd0);
    check("rst_all_same", 64'(bus.out_all_same), 64'd0);
    check("rst_tag", 64'(bus.out_tag), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_rst", 64'(bus.in_ready), 64'd1);

    // Latency of a single beat
    send(0);
    check("lat_stage1", 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    #1;
    check("lat_out", 64'(bus.out_valid), 64'd1);
    repeat (3) @(posedge clk);
    #1;

    // Individual directed vectors
    single(1); single(2); single(3); single(4);
    single(8); single(9); single(10); single(11); single(12); single(13);

    // Back-to-back stream of 6 beats
    max_run = 0;
    for (int i = 5; i <= 10; i++) send(i);
    repeat (5) @(posedge clk);
    #1;
    check("stream_run", 64'(max_run), 64'd6);

    // Stream 4 beats with a 3-cycle output stall
    fork
      begin
        send(11); send(12); send(13); send(1);
      end
      begin
        w = 0;
        while (!bus.out_valid && w < 50) begin
          @(posedge clk);
          #1;
          w++;
        end
        if (!bus.out_valid) check("stall_wait_timeout", 64'd0, 64'd1);
        bus.out_ready = 1'b0;
        snap_cnt  = bus.out_count;
        snap_norm = bus.out_norm;
        snap_tag  = bus.out_tag;
        repeat (3) begin
          @(negedge clk);
          check("stall_in_ready", 64'(bus.in_ready), 64'd0);
          check("stall_valid", 64'(bus.out_valid), 64'd1);
          check("stall_count", 64'(bus.out_count), 64'(snap_cnt));
          check("stall_norm", 64'(bus.out_norm), 64'(snap_norm));
          check("stall_tag", 64'(bus.out_tag), 64'(snap_tag));
          @(posedge clk);
          #1;
        end
        bus.out_ready = 1'b1;
      end
    join
    repeat (6) @(posedge clk);
    #1;
    check("stall_drained", 64'(sb.size()), 64'd0);

    // Reset with two beats in flight
    send(5);
    send(6);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_in_ready", 64'(bus.in_ready), 64'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("no_stale_beat", 64'(bus.out_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    send(7);
    check("post_rst_stage1", 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    #1;
    check("post_rst_lat", 64'(bus.out_valid), 64'd1);
    repeat (4) @(posedge clk);
    #1;
    check("final_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
